// File: rtl/puc_cpu_param_if.sv
// Instruction fetch port of puc_cpu_param: the CPU drives pc and the memory
// returns a valid-qualified instruction word for that address.
interface puc_cpu_param_if #(
  parameter int PC_WIDTH    = 6,
  parameter int INSTR_WIDTH = 15
);
  logic [INSTR_WIDTH-1:0] instruction;
  logic                   instructionValid;
  logic [PC_WIDTH-1:0]    pc;

  modport master (input instruction, input instructionValid, output pc);
  modport slave  (output instruction, output instructionValid, input pc);
endinterface

// File: rtl/puc_cpu_param.sv
// puc_cpu_param: single-cycle accumulator CPU with flags, conditional jumps and HALT.
// Defining PUC_CALL_EN adds a STACK_DEPTH-entry return stack and the stackError output.
module puc_cpu_param #(
  parameter int DATA_WIDTH  = 8,
  parameter int PC_WIDTH    = 6,
  parameter int NUM_REGS    = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  resetN,
  puc_cpu_param_if.master       fetch,
  input  logic                  run,
  output logic [DATA_WIDTH-1:0] accumulator,
  output logic [DATA_WIDTH-1:0] registerValue,
  output logic [DATA_WIDTH-1:0] aluResult,
  output logic                  zeroFlag,
  output logic                  carryFlag,
  output logic                  halted,
  output logic                  isReset
`ifdef PUC_CALL_EN
  ,
  output logic                  stackError
`endif
);
  localparam int SEL_WIDTH = $clog2(NUM_REGS);
  localparam int IW        = 4 + SEL_WIDTH + DATA_WIDTH;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  localparam logic [3:0] OP_LOADI = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_MOVE  = 4'h7;
  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_JUMP  = 4'h9;
  localparam logic [3:0] OP_JZ    = 4'hA;
  localparam logic [3:0] OP_JC    = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hC;
  localparam logic [3:0] OP_RESET = 4'hD;
`ifdef PUC_CALL_EN
  localparam logic [3:0] OP_CALL  = 4'hE;
  localparam logic [3:0] OP_RET   = 4'hF;
`endif

  logic [0:0]            state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d, pc_inc;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic                  z_q, z_d, c_q, c_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                  reg_we, sel_ok;
  logic [DATA_WIDTH-1:0] rd_val;
  logic [DATA_WIDTH:0]   alu_w;

  logic [3:0]            op;
  logic [SEL_WIDTH-1:0]  sel;
  logic [DATA_WIDTH-1:0] imm;
  logic [PC_WIDTH-1:0]   target;

  assign op     = fetch.instruction[IW-1 -: 4];
  assign sel    = fetch.instruction[DATA_WIDTH +: SEL_WIDTH];
  assign imm    = fetch.instruction[DATA_WIDTH-1:0];
  assign target = imm[PC_WIDTH-1:0];
  assign pc_inc = pc_q + PC_WIDTH'(1);

  // Only a non power-of-two register file can see an out-of-range select.
  if (NUM_REGS == (1 << SEL_WIDTH)) begin : g_sel_full
    assign sel_ok = 1'b1;
  end else begin : g_sel_part
    assign sel_ok = (sel < SEL_WIDTH'(NUM_REGS));
  end

  assign rd_val = sel_ok ? regs_q[sel] : '0;

  always_comb begin
    case (op)
      OP_LOADI: alu_w = {1'b0, imm};
      OP_ADD:   alu_w = {1'b0, acc_q} + {1'b0, rd_val};
      OP_SUB:   alu_w = {1'b0, acc_q} - {1'b0, rd_val};
      OP_AND:   alu_w = {1'b0, acc_q & rd_val};
      OP_OR:    alu_w = {1'b0, acc_q | rd_val};
      OP_XOR:   alu_w = {1'b0, acc_q ^ rd_val};
      OP_LOAD:  alu_w = {1'b0, rd_val};
      default:  alu_w = {1'b0, acc_q};
    endcase
  end

`ifdef PUC_CALL_EN
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam int SI_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_WIDTH-1:0] stk_q [STACK_DEPTH];
  logic [SP_W-1:0]     sp_q;
  logic                push, pop, clr_stack, err_q, err_d, stk_full, stk_empty;
  logic [SI_W-1:0]     wr_idx, rd_idx;

  assign stk_full   = (sp_q == SP_W'(STACK_DEPTH));
  assign stk_empty  = (sp_q == '0);
  assign wr_idx     = SI_W'(sp_q);
  assign rd_idx     = SI_W'(sp_q - SP_W'(1));
  assign stackError = err_q;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    z_d     = z_q;
    c_d     = c_q;
    reg_we  = 1'b0;
`ifdef PUC_CALL_EN
    push      = 1'b0;
    pop       = 1'b0;
    clr_stack = 1'b0;
    err_d     = err_q;
`endif
    if (state_q == ST_HALTED) begin
      if (run) state_d = ST_RUN;
    end else if (fetch.instructionValid) begin
      pc_d = pc_inc;
      case (op)
        OP_LOADI, OP_LOAD: begin
          acc_d = alu_w[DATA_WIDTH-1:0];
          z_d   = (alu_w[DATA_WIDTH-1:0] == '0);
        end
        OP_ADD, OP_SUB: begin
          acc_d = alu_w[DATA_WIDTH-1:0];
          z_d   = (alu_w[DATA_WIDTH-1:0] == '0);
          c_d   = alu_w[DATA_WIDTH];
        end
        OP_AND, OP_OR, OP_XOR: begin
          acc_d = alu_w[DATA_WIDTH-1:0];
          z_d   = (alu_w[DATA_WIDTH-1:0] == '0);
          c_d   = 1'b0;
        end
        OP_MOVE:  reg_we = sel_ok;
        OP_JUMP:  pc_d = target;
        OP_JZ:    if (z_q) pc_d = target;
        OP_JC:    if (c_q) pc_d = target;
        OP_HALT:  state_d = ST_HALTED;
        OP_RESET: begin
          pc_d  = '0;
          acc_d = '0;
          z_d   = 1'b0;
          c_d   = 1'b0;
`ifdef PUC_CALL_EN
          clr_stack = 1'b1;
`endif
        end
`ifdef PUC_CALL_EN
        OP_CALL: begin
          if (stk_full) err_d = 1'b1;
          else begin
            push = 1'b1;
            pc_d = target;
          end
        end
        OP_RET: begin
          if (stk_empty) err_d = 1'b1;
          else begin
            pop  = 1'b1;
            pc_d = stk_q[rd_idx];
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      acc_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      c_q     <= c_d;
      if (reg_we) regs_q[sel] <= acc_q;
    end
  end

`ifdef PUC_CALL_EN
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      sp_q  <= '0;
      err_q <= 1'b0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
    end else begin
      err_q <= err_d;
      if (clr_stack) sp_q <= '0;
      else if (push) begin
        stk_q[wr_idx] <= pc_inc;
        sp_q          <= sp_q + SP_W'(1);
      end else if (pop) sp_q <= sp_q - SP_W'(1);
    end
  end
`endif

  assign fetch.pc      = pc_q;
  assign accumulator   = acc_q;
  assign registerValue = rd_val;
  assign aluResult     = alu_w[DATA_WIDTH-1:0];
  assign zeroFlag      = z_q;
  assign carryFlag     = c_q;
  assign halted        = (state_q == ST_HALTED);
  assign isReset       = (state_q == ST_RUN) && fetch.instructionValid && (op == OP_RESET);
endmodule
